mips_trace_monitor: RTL and testbench

- Synthesisable run harness for the 16-bit single-cycle MIPS core.
- Generates the core's reset sequence, then compares the core's pc_out and alu_result each cycle against a loaded expected-trace table.
- Reports pass/fail, the mismatch count and the first failing step.
- Sits beside mips_16 in the top level or on an FPGA; replaces hand-timed reset and manual waveform inspection.

---
 rtl/mips_trace_monitor.sv | 149 ++++++++++++++
 tb/tb_mips_trace_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_monitor.sv
// Run harness for the 16-bit single-cycle MIPS core: sequences the core reset,
// then checks pc/alu_result against a loaded expected trace, one step per cycle.
module mips_trace_monitor #(
    parameter int DATA_W       = 16,
    parameter int TRACE_DEPTH  = 16,
    parameter int TRACE_AW     = 4,
    parameter int RST_CYCLES   = 5,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [TRACE_AW:0]   trace_len,
    input  logic                ld_valid,
    input  logic [TRACE_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0]   ld_pc,
    input  logic [DATA_W-1:0]   ld_alu,
    input  logic                ld_chk_alu,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [DATA_W-1:0]   alu_in,
    output logic                core_reset,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [TRACE_AW:0]   mismatch_count,
    output logic [TRACE_AW-1:0] first_fail_idx,
    output logic                fail_seen
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [TRACE_AW:0]  LEN_MAX   = (TRACE_AW+1)'(TRACE_DEPTH);
    localparam logic [TRACE_AW:0]  LEN_ONE   = (TRACE_AW+1)'(1);
    localparam logic [TRACE_AW:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_RST = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TRACE_AW:0]   step_cnt;
    logic [TRACE_AW:0]   len_q;
    logic [TRACE_AW:0]   len_eff;
    logic [TRACE_AW:0]   last_step;
    logic [TRACE_AW-1:0] idx;
    logic                mismatch_now;
    logic                stop_now;

    logic [DATA_W-1:0]   trace_pc  [TRACE_DEPTH];
    logic [DATA_W-1:0]   trace_alu [TRACE_DEPTH];
    logic                trace_chk [TRACE_DEPTH];

    // Trace table has no reset; writes are locked out while a run is comparing.
    always_ff @(posedge clk) begin
        if (ld_valid && (state != RUN)) begin
            trace_pc[ld_addr]  <= ld_pc;
            trace_alu[ld_addr] <= ld_alu;
            trace_chk[ld_addr] <= ld_chk_alu;
        end
    end

    always_comb begin
        len_eff      = (trace_len > LEN_MAX) ? LEN_MAX : trace_len;
        last_step    = len_q - LEN_ONE;
        idx          = step_cnt[TRACE_AW-1:0];
        mismatch_now = (pc_in != trace_pc[idx]) ||
                       (trace_chk[idx] && (alu_in != trace_alu[idx]));
        stop_now     = (STOP_ON_FAIL != 0) && mismatch_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            core_reset     <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail_seen      <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            step_cnt       <= '0;
            hold_cnt       <= '0;
            len_q          <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= HOLD_RST;
                        core_reset     <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        fail_seen      <= 1'b0;
                        mismatch_count <= '0;
                        first_fail_idx <= '0;
                        step_cnt       <= '0;
                        hold_cnt       <= '0;
                        len_q          <= len_eff;
                    end
                end
                HOLD_RST: begin
                    if (hold_cnt == HOLD_LAST) begin
                        // An empty trace finishes without ever releasing the core.
                        if (len_q == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (mismatch_now) begin
                        fail_seen <= 1'b1;
                        if (mismatch_count != CNT_MAX) begin
                            mismatch_count <= mismatch_count + LEN_ONE;
                        end
                        if (!fail_seen) begin
                            first_fail_idx <= idx;
                        end
                    end
                    if ((step_cnt == last_step) || stop_now) begin
                        state      <= DONE;
                        core_reset <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt + LEN_ONE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    core_reset <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    assign pass = done & ~fail_seen;

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Directed bench for mips_trace_monitor: two instances (continue / stop on fail)
// each driven by a tiny stand-in core whose pc steps by 2 and alu = pc + 0x100.
module tb_mips_trace_monitor;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  trace_len;
    logic        ld_valid;
    logic [3:0]  ld_addr;
    logic [15:0] ld_pc;
    logic [15:0] ld_alu;
    logic        ld_chk_alu;

    logic [15:0] pc_a, pc_b;
    logic [15:0] alu_a, alu_b;

    logic        core_reset_a, busy_a, done_a, pass_a, fail_seen_a;
    logic [4:0]  count_a;
    logic [3:0]  ffi_a;
    logic        core_reset_b, busy_b, done_b, pass_b, fail_seen_b;
    logic [4:0]  count_b;
    logic [3:0]  ffi_b;

    int checks = 0;
    int errors = 0;

    mips_trace_monitor #(.STOP_ON_FAIL(0)) dut (
        .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_pc(ld_pc), .ld_alu(ld_alu),
        .ld_chk_alu(ld_chk_alu), .pc_in(pc_a), .alu_in(alu_a),
        .core_reset(core_reset_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .mismatch_count(count_a), .first_fail_idx(ffi_a), .fail_seen(fail_seen_a)
    );

    mips_trace_monitor #(.STOP_ON_FAIL(1)) dut_sof (
        .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_pc(ld_pc), .ld_alu(ld_alu),
        .ld_chk_alu(ld_chk_alu), .pc_in(pc_b), .alu_in(alu_b),
        .core_reset(core_reset_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .mismatch_count(count_b), .first_fail_idx(ffi_b), .fail_seen(fail_seen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pc_a <= core_reset_a ? 16'h0000 : pc_a + 16'h0002;
        pc_b <= core_reset_b ? 16'h0000 : pc_b + 16'h0002;
    end
    assign alu_a = pc_a + 16'h0100;
    assign alu_b = pc_b + 16'h0100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input logic [3:0] a, input logic [15:0] p,
                              input logic [15:0] v, input logic c);
        ld_valid   = 1'b1;
        ld_addr    = a;
        ld_pc      = p;
        ld_alu     = v;
        ld_chk_alu = c;
        tick();
        ld_valid   = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] len);
        start     = 1'b1;
        trace_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done_a(output int cycles);
        cycles = 0;
        while (!done_a && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (core_reset_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_core_reset got %0b exp 1", core_reset_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b exp 0", done_a); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got %0b exp 0", pass_a); end
        checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", count_a); end
        checks++; if (ffi_a !== 4'd0) begin errors++; $display("[TB] FAIL reset_ffi got %0d exp 0", ffi_a); end
        checks++; if (fail_seen_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_fail_seen got %0b exp 0", fail_seen_a); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pass_run();
        int hold, cyc;
        for (int i = 0; i < 4; i++) begin
            load_entry(4'(i), 16'(2 * i), 16'(2 * i + 16'h0100), 1'b1);
        end
        start_run(5'd4);
        hold = 0;
        while (core_reset_a && hold < 50) begin
            hold++;
            tick();
        end
        checks++; if (hold !== 5) begin errors++; $display("[TB] FAIL pass_hold_cycles got %0d exp 5", hold); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL pass_busy_in_run got %0b exp 1", busy_a); end
        wait_done_a(cyc);
        checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL pass_run_cycles got %0d exp 4", cyc); end
        checks++; if (pass_a !== 1'b1) begin errors++; $display("[TB] FAIL pass_pass got %0b exp 1", pass_a); end
        checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL pass_count got %0d exp 0", count_a); end
        checks++; if (core_reset_a !== 1'b1) begin errors++; $display("[TB] FAIL pass_core_halted got %0b exp 1", core_reset_a); end
        checks++; if (pass_b !== 1'b1) begin errors++; $display("[TB] FAIL pass_sof_pass got %0b exp 1", pass_b); end
    endtask

    task automatic test_alu_mismatch();
        int cyc;
        load_entry(4'd2, 16'h0004, 16'hDEAD, 1'b1);
        start_run(5'd4);
        wait_done_a(cyc);
        checks++; if (done_a !== 1'b1) begin errors++; $display("[TB] FAIL alu_done got %0b exp 1", done_a); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("[TB] FAIL alu_pass got %0b exp 0", pass_a); end
        checks++; if (count_a !== 5'd1) begin errors++; $display("[TB] FAIL alu_count got %0d exp 1", count_a); end
        checks++; if (ffi_a !== 4'd2) begin errors++; $display("[TB] FAIL alu_ffi got %0d exp 2", ffi_a); end
        checks++; if (fail_seen_a !== 1'b1) begin errors++; $display("[TB] FAIL alu_fail_seen got %0b exp 1", fail_seen_a); end
        checks++; if (ffi_b !== 4'd2) begin errors++; $display("[TB] FAIL alu_sof_ffi got %0d exp 2", ffi_b); end
    endtask

    task automatic test_alu_ignore();
        int cyc;
        load_entry(4'd2, 16'h0004, 16'hDEAD, 1'b0);
        start_run(5'd4);
        wait_done_a(cyc);
        checks++; if (pass_a !== 1'b1) begin errors++; $display("[TB] FAIL ignore_pass got %0b exp 1", pass_a); end
        checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL ignore_count got %0d exp 0", count_a); end
    endtask

    task automatic test_stop_on_fail();
        int wait_cyc, cyc;
        load_entry(4'd2, 16'h0004, 16'h0104, 1'b1);
        load_entry(4'd1, 16'h0002, 16'hDEAD, 1'b1);
        load_entry(4'd3, 16'h00FF, 16'h0106, 1'b1);
        start_run(5'd4);
        wait_cyc = 0;
        while (core_reset_b && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        cyc = 0;
        while (!done_b && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++; if (cyc !== 2) begin errors++; $display("[TB] FAIL sof_stop_cycles got %0d exp 2", cyc); end
        checks++; if (count_b !== 5'd1) begin errors++; $display("[TB] FAIL sof_count got %0d exp 1", count_b); end
        checks++; if (ffi_b !== 4'd1) begin errors++; $display("[TB] FAIL sof_ffi got %0d exp 1", ffi_b); end
        checks++; if (core_reset_b !== 1'b1) begin errors++; $display("[TB] FAIL sof_core_halted got %0b exp 1", core_reset_b); end
        wait_done_a(cyc);
        checks++; if (count_a !== 5'd2) begin errors++; $display("[TB] FAIL nosof_count got %0d exp 2", count_a); end
        checks++; if (ffi_a !== 4'd1) begin errors++; $display("[TB] FAIL nosof_ffi got %0d exp 1", ffi_a); end
    endtask

    task automatic test_zero_len_and_locked_load();
        int cyc;
        logic released;
        load_entry(4'd1, 16'h0002, 16'h0102, 1'b1);
        load_entry(4'd3, 16'h0006, 16'h0106, 1'b1);
        start_run(5'd0);
        cyc = 0;
        released = 1'b0;
        while (!done_a && cyc < 50) begin
            tick();
            cyc++;
            if (!core_reset_a) released = 1'b1;
        end
        checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL zero_done_cycles got %0d exp 5", cyc); end
        checks++; if (released !== 1'b0) begin errors++; $display("[TB] FAIL zero_core_released got %0b exp 0", released); end
        checks++; if (pass_a !== 1'b1) begin errors++; $display("[TB] FAIL zero_pass got %0b exp 1", pass_a); end

        start_run(5'd4);
        cyc = 0;
        while (core_reset_a && cyc < 50) begin
            tick();
            cyc++;
        end
        load_entry(4'd1, 16'h0002, 16'hDEAD, 1'b1);
        wait_done_a(cyc);
        checks++; if (pass_a !== 1'b1) begin errors++; $display("[TB] FAIL locked_pass got %0b exp 1", pass_a); end
        start_run(5'd4);
        wait_done_a(cyc);
        checks++; if (pass_a !== 1'b1) begin errors++; $display("[TB] FAIL locked_rerun_pass got %0b exp 1", pass_a); end
        checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL locked_rerun_count got %0d exp 0", count_a); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        load_entry(4'd0, 16'h0077, 16'h0100, 1'b1);
        start_run(5'd4);
        cyc = 0;
        while (core_reset_a && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        checks++; if (count_a !== 5'd1) begin errors++; $display("[TB] FAIL midrun_count got %0d exp 1", count_a); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (core_reset_a !== 1'b1) begin errors++; $display("[TB] FAIL midrun_core_reset got %0b exp 1", core_reset_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL midrun_busy got %0b exp 0", busy_a); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL after_reset_count got %0d exp 0", count_a); end
        checks++; if (fail_seen_a !== 1'b0) begin errors++; $display("[TB] FAIL after_reset_fail_seen got %0b exp 0", fail_seen_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL after_reset_done got %0b exp 0", done_a); end
        load_entry(4'd0, 16'h0000, 16'h0100, 1'b1);
        start_run(5'd4);
        wait_done_a(cyc);
        checks++; if (pass_a !== 1'b1) begin errors++; $display("[TB] FAIL after_reset_pass got %0b exp 1", pass_a); end
        checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL after_reset_run_count got %0d exp 0", count_a); end
    endtask

    initial begin
        start      = 1'b0;
        trace_len  = 5'd0;
        ld_valid   = 1'b0;
        ld_addr    = 4'd0;
        ld_pc      = 16'h0000;
        ld_alu     = 16'h0000;
        ld_chk_alu = 1'b0;
        test_reset();
        test_pass_run();
        test_alu_mismatch();
        test_alu_ignore();
        test_stop_on_fail();
        test_zero_len_and_locked_load();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
